// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Purpose  : Shared definitions for the data-memory responder. It holds the
//            responder state encoding, the legal byte-enable patterns, the
//            word size, and the sub-word alignment helper.
// Ports    : none (package)
// Options  : DMEM_SUBWORD_EN selects whether the alignment helper is used
//            by the responder.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  localparam int unsigned c_word_bits = 32;
  localparam int unsigned c_be_bits   = c_word_bits / 8;
  localparam int unsigned c_wait_bits = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Legal byte-enable patterns
  localparam logic [c_be_bits-1:0] c_be_word    = 4'hF;
  localparam logic [c_be_bits-1:0] c_be_half_lo = 4'h3;
  localparam logic [c_be_bits-1:0] c_be_half_hi = 4'hC;
  localparam logic [c_be_bits-1:0] c_be_byte0   = 4'h1;
  localparam logic [c_be_bits-1:0] c_be_byte1   = 4'h2;
  localparam logic [c_be_bits-1:0] c_be_byte2   = 4'h4;
  localparam logic [c_be_bits-1:0] c_be_byte3   = 4'h8;

  // The enable pattern sets the access size. The address offset must be
  // aligned to that size: a word needs offset 0, a halfword needs an even
  // offset, and a byte can use any offset. Any other enable pattern is
  // rejected.
  function automatic logic f_subword_misaligned(input logic [c_be_bits-1:0] be,
                                                input logic [1:0]           off);
    logic v_bad;
    v_bad = 1'b1;
    case (be)
      c_be_word:                    v_bad = (off != 2'b00);
      c_be_half_lo, c_be_half_hi:   v_bad = off[0];
      c_be_byte0, c_be_byte1,
      c_be_byte2, c_be_byte3:       v_bad = 1'b0;
      default:                      v_bad = 1'b1;
    endcase
    return v_bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Purpose  : Request/response bundle between the load/store stage (master)
//            and the data-memory responder (slave).
// Signals  : req_valid/req_ready/req_write/req_addr/req_wdata/req_be
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  import mips_mem_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [c_word_bits-1:0] req_addr;
  logic [c_word_bits-1:0] req_wdata;
  logic [c_be_bits-1:0]   req_be;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [c_word_bits-1:0] rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Synchronous single-port word array. It has a per-byte write
//            enable and a registered read. It holds storage only and is
//            never cleared. The read register changes only on an enabled
//            read, so it keeps its value between accesses.
// Ports    : clk     - clock
//            i_en    - access enable
//            i_we    - 1 = write enabled bytes, 0 = read word
//            i_addr  - word index
//            i_wdata - write data
//            i_be    - byte enables
//            o_rdata - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   i_en,
  input  logic                   i_we,
  input  logic [ADDR_BITS-1:0]   i_addr,
  input  logic [c_word_bits-1:0] i_wdata,
  input  logic [c_be_bits-1:0]   i_be,
  output logic [c_word_bits-1:0] o_rdata
);

  logic [c_word_bits-1:0] r_mem [DEPTH_WORDS];
  logic [c_word_bits-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < c_be_bits; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Handshaked data-memory slave for the MIPS load/store stage with
//            wait states. A request is accepted in IDLE. The block then
//            waits WAIT_CYCLES cycles in WAIT and presents the response in
//            RESP until it is taken. The array is accessed on the edge that
//            enters RESP.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            io_bus - dmem_responder_if.slave request/response bundle
// Options  : DMEM_SUBWORD_EN - when defined, byte enables are honoured for
//            stores and alignment is checked against the access size. When
//            it is undefined, every store is full-word and any non-zero
//            address offset is an error.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,  // power of 2, at least 2
  parameter int unsigned WAIT_CYCLES = 1     // 0..15
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave io_bus
);

  localparam int unsigned c_idx_bits = $clog2(DEPTH_WORDS);
  localparam logic [c_wait_bits-1:0] c_wait_load =
    (WAIT_CYCLES == 0) ? '0 : c_wait_bits'(WAIT_CYCLES - 1);
  localparam logic [c_wait_bits-1:0] c_wait_one = 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_wait_bits-1:0]  r_wcnt;

  // Request fields latched on accept
  logic                    r_write;
  logic [c_idx_bits-1:0]   r_idx;
  logic [c_word_bits-1:0]  r_wdata;
  logic [c_be_bits-1:0]    r_be;
  logic                    r_err;

  // Response qualifiers
  logic                    r_rsp_err;
  logic                    r_ld_ok;

  logic                    w_req_ready;
  logic                    w_rsp_valid;
  logic                    w_accept;
  logic                    w_enter_resp;
  logic                    w_leave_resp;
  logic                    w_in_idle;

  logic                    w_oor;
  logic                    w_misaligned;
  logic                    w_req_err;
  logic [c_be_bits-1:0]    w_req_be;

  logic                    w_cur_write;
  logic [c_idx_bits-1:0]   w_cur_idx;
  logic [c_word_bits-1:0]  w_cur_wdata;
  logic [c_be_bits-1:0]    w_cur_be;
  logic                    w_cur_err;

  logic                    w_mem_en;
  logic [c_word_bits-1:0]  w_mem_rdata;

  // --------------------------------------------------------------------------
  // Request error classification. This is evaluated on the incoming request
  // and is only meaningful in the accept cycle.
  // --------------------------------------------------------------------------
  assign w_oor = |(io_bus.req_addr >> (c_idx_bits + 2));

`ifdef DMEM_SUBWORD_EN
  assign w_misaligned = f_subword_misaligned(io_bus.req_be, io_bus.req_addr[1:0]);
  assign w_req_be     = io_bus.req_be;
`else
  logic w_unused_be;
  assign w_misaligned = (io_bus.req_addr[1:0] != 2'b00);
  assign w_req_be     = c_be_word;
  assign w_unused_be  = ^io_bus.req_be;
`endif

  assign w_req_err = w_oor | w_misaligned;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (io_bus.req_valid) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_wcnt == '0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (io_bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_accept     = w_req_ready & io_bus.req_valid;
  assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
  assign w_leave_resp = (r_state == ST_RESP) && io_bus.rsp_ready;

  // --------------------------------------------------------------------------
  // Request latch and wait counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt  <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_wcnt  <= c_wait_load;
      r_write <= io_bus.req_write;
      r_idx   <= io_bus.req_addr[c_idx_bits+1:2];
      r_wdata <= io_bus.req_wdata;
      r_be    <= w_req_be;
      r_err   <= w_req_err;
    end else if ((r_state == ST_WAIT) && (r_wcnt != '0)) begin
      r_wcnt  <= r_wcnt - c_wait_one;
    end
  end

  // With zero wait states, RESP is entered on the accept edge itself. The
  // latch is not loaded yet at that point, so the access uses the live
  // request instead.
  assign w_cur_write = w_in_idle ? io_bus.req_write                   : r_write;
  assign w_cur_idx   = w_in_idle ? io_bus.req_addr[c_idx_bits+1:2]    : r_idx;
  assign w_cur_wdata = w_in_idle ? io_bus.req_wdata                   : r_wdata;
  assign w_cur_be    = w_in_idle ? w_req_be                           : r_be;
  assign w_cur_err   = w_in_idle ? w_req_err                          : r_err;

  // The rst_n gate keeps a request that is held during reset from writing.
  assign w_mem_en = rst_n & w_enter_resp & ~w_cur_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_BITS   (c_idx_bits)
  ) u_array (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (w_cur_write),
    .i_addr  (w_cur_idx),
    .i_wdata (w_cur_wdata),
    .i_be    (w_cur_be),
    .o_rdata (w_mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Response qualifiers. r_ld_ok passes the array read register through
  // only for a good load. Stores, errors and idle cycles therefore return
  // zero, and the array read register needs no reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
      r_ld_ok   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rsp_err <= w_cur_err;
      r_ld_ok   <= ~w_cur_write & ~w_cur_err;
    end else if (w_leave_resp) begin
      r_rsp_err <= 1'b0;
      r_ld_ok   <= 1'b0;
    end
  end

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_err   = r_rsp_err;
  assign io_bus.rsp_rdata = r_ld_ok ? w_mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. It drives three
//            instances with WAIT_CYCLES = 1, 4 and 0 and compares them
//            against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [2:0]  v;
  logic [2:0]  w;
  logic [2:0]  rr;
  logic [31:0] a  [3];
  logic [31:0] wd [3];
  logic [3:0]  be [3];
  logic [2:0]  rdy;
  logic [2:0]  rv;
  logic [2:0]  re;
  logic [31:0] rd [3];

  logic [31:0] mem [3][256];
  int n_checks = 0;
  int n_errors = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned c_wait = (g == 0) ? 1 : ((g == 1) ? 4 : 0);
      dmem_responder_if u_if ();
      assign u_if.req_valid = v[g];
      assign u_if.req_write = w[g];
      assign u_if.req_addr  = a[g];
      assign u_if.req_wdata = wd[g];
      assign u_if.req_be    = be[g];
      assign u_if.rsp_ready = rr[g];
      assign rdy[g] = u_if.req_ready;
      assign rv[g]  = u_if.rsp_valid;
      assign re[g]  = u_if.rsp_err;
      assign rd[g]  = u_if.rsp_rdata;
      dmem_responder #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (c_wait)
      ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n[g]),
        .io_bus (u_if)
      );
    end
  endgenerate

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 0);
  endfunction

  // A request is in error when it lies beyond 256 words (1024 bytes) or when
  // it is not aligned to its access size.
  function automatic bit exp_err(input logic [31:0] addr, input logic [3:0] b);
    if (addr >= 32'd1024) return 1'b1;
`ifdef DMEM_SUBWORD_EN
    case (b)
      4'hF:                return (addr % 4) != 0;
      4'h3, 4'hC:          return (addr % 2) != 0;
      4'h1, 4'h2, 4'h4, 4'h8: return 1'b0;
      default:             return 1'b1;
    endcase
`else
    return ((addr % 4) != 0) || (b === 4'bzzzz);
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_SUBWORD_EN
      if (b[i]) res[8*i +: 8] = nw[8*i +: 8];
`else
      if (b !== 4'bzzzz) res[8*i +: 8] = nw[8*i +: 8];
`endif
    end
    return res;
  endfunction

  function automatic logic [3:0] pick_be(input int r);
    case (r)
      0: return 4'hF; 1: return 4'h3; 2: return 4'hC; 3: return 4'h1;
      4: return 4'h2; 5: return 4'h4; 6: return 4'h8; 7: return 4'h5;
      default: return 4'hF;
    endcase
  endfunction

  // One complete transaction on instance d. It checks the latency, the
  // response contents, that the response holds steady under backpressure,
  // and the return to idle.
  task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] b, input int hold,
                     input bit intrude, output logic [31:0] got_rd, output logic got_err);
    bit          e_err;
    logic [31:0] e_rd;
    int          lat;
    bit          stay_ok;
    logic [31:0] rd0;
    logic        re0;
    e_err   = exp_err(addr, b);
    e_rd    = (!wr && !e_err) ? mem[d][addr[9:2]] : 32'h0;
    got_rd  = 32'h0;
    got_err = 1'b0;
    n_checks++;
    if (rdy[d] !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_ready d=%0d: got %b want 1", d, rdy[d]);
    end
    v[d] = 1'b1; w[d] = wr; a[d] = addr; wd[d] = wdata; be[d] = b;
    @(posedge clk); #1;
    v[d] = 1'b0; a[d] = $urandom; wd[d] = $urandom; be[d] = 4'($urandom);
    lat = 0; stay_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (rv[d] === 1'b1) begin
        lat = k;
        break;
      end
      if (rdy[d] !== 1'b0) stay_ok = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++;
    if (lat != wait_of(d) + 1) begin
      n_errors++;
      $display("FAIL latency d=%0d addr=%h: got %0d want %0d", d, addr, lat, wait_of(d) + 1);
    end
    if (lat == 0) return;
    got_rd = rd[d]; got_err = re[d];
    n_checks++;
    if (rd[d] !== e_rd) begin
      n_errors++;
      $display("FAIL rdata d=%0d wr=%0d addr=%h be=%h: got %h want %h", d, wr, addr, b, rd[d], e_rd);
    end
    n_checks++;
    if (re[d] !== e_err) begin
      n_errors++;
      $display("FAIL err d=%0d wr=%0d addr=%h be=%h: got %b want %b", d, wr, addr, b, re[d], e_err);
    end
    rd0 = rd[d]; re0 = re[d];
    if (intrude) begin
      v[d] = 1'b1; w[d] = 1'b1; a[d] = 32'h30; wd[d] = 32'hBAD0BAD0; be[d] = 4'hF;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (rdy[d] !== 1'b0 || rv[d] !== 1'b1 || rd[d] !== rd0 || re[d] !== re0) stay_ok = 1'b0;
    end
    n_checks++;
    if (!stay_ok) begin
      n_errors++;
      $display("FAIL busy_stable d=%0d addr=%h: got rdy=%b rv=%b rd=%h want rdy=0 rv=1 rd=%h",
               d, addr, rdy[d], rv[d], rd[d], rd0);
    end
    v[d] = 1'b0; rr[d] = 1'b1;
    @(posedge clk); #1;
    rr[d] = 1'b0;
    n_checks++;
    if (rv[d] !== 1'b0 || rdy[d] !== 1'b1) begin
      n_errors++;
      $display("FAIL release d=%0d: got rv=%b rdy=%b want rv=0 rdy=1", d, rv[d], rdy[d]);
    end
    if (wr && !e_err) mem[d][addr[9:2]] = merge(mem[d][addr[9:2]], wdata, b);
  endtask

  task automatic test_reset;
    rst_n = 3'b000; v = '0; w = '0; rr = '0;
    for (int d = 0; d < 3; d++) begin
      a[d] = '0; wd[d] = '0; be[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (rdy[d] !== 1'b1) begin n_errors++; $display("FAIL reset_ready d=%0d: got %b want 1", d, rdy[d]); end
      n_checks++;
      if (rv[d] !== 1'b0) begin n_errors++; $display("FAIL reset_valid d=%0d: got %b want 0", d, rv[d]); end
      n_checks++;
      if (rd[d] !== 32'h0) begin n_errors++; $display("FAIL reset_rdata d=%0d: got %h want 0", d, rd[d]); end
      n_checks++;
      if (re[d] !== 1'b0) begin n_errors++; $display("FAIL reset_err d=%0d: got %b want 0", d, re[d]); end
    end
    rst_n = 3'b111;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    logic [31:0] g; logic ge;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, g, ge);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, g, ge);
    n_checks++;
    if (g !== 32'hDEADBEEF) begin n_errors++; $display("FAIL store_load: got %h want deadbeef", g); end
  endtask

  task automatic test_backpressure;
    logic [31:0] g; logic ge;
    txn(0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 0, 1'b0, g, ge);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1, g, ge);
    txn(0, 1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b0, g, ge);
    n_checks++;
    if (g !== 32'h0BADF00D) begin n_errors++; $display("FAIL intruder_ignored: got %h want 0badf00d", g); end
  endtask

  task automatic test_errors;
    logic [31:0] g; logic ge;
    txn(0, 1'b1, 32'h13, 32'h12345678, 4'hF, 0, 1'b0, g, ge);
    n_checks++;
    if (ge !== 1'b1) begin n_errors++; $display("FAIL misaligned_err: got %b want 1", ge); end
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, g, ge);
    n_checks++;
    if (g !== 32'hDEADBEEF) begin n_errors++; $display("FAIL misaligned_nowrite: got %h want deadbeef", g); end
    txn(0, 1'b0, 32'h400, 32'h0, 4'hF, 1, 1'b0, g, ge);
    n_checks++;
    if (ge !== 1'b1 || g !== 32'h0) begin
      n_errors++; $display("FAIL range_err: got err=%b rd=%h want err=1 rd=0", ge, g);
    end
  endtask

  task automatic test_subword;
    logic [31:0] g; logic ge; logic [31:0] want;
`ifdef DMEM_SUBWORD_EN
    want = 32'h1122AA44;
`else
    want = 32'h0000AA00;
`endif
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, g, ge);
    txn(0, 1'b1, 32'h20, 32'h0000AA00, 4'h2, 0, 1'b0, g, ge);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, g, ge);
    n_checks++;
    if (g !== want) begin n_errors++; $display("FAIL subword: got %h want %h", g, want); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] g; logic ge;
    txn(2, 1'b1, 32'h44, 32'hCAFE1234, 4'hF, 0, 1'b0, g, ge);
    txn(2, 1'b0, 32'h44, 32'h0, 4'hF, 0, 1'b0, g, ge);
    n_checks++;
    if (g !== 32'hCAFE1234) begin n_errors++; $display("FAIL back_to_back_w0: got %h want cafe1234", g); end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] g; logic ge;
    txn(1, 1'b1, 32'h8, 32'hA5A50001, 4'hF, 0, 1'b0, g, ge);
    v[1] = 1'b1; w[1] = 1'b1; a[1] = 32'h8; wd[1] = 32'h5A5AFFFF; be[1] = 4'hF;
    @(posedge clk); #1;
    v[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (rv[1] !== 1'b0 || rdy[1] !== 1'b0) begin
      n_errors++; $display("FAIL mid_wait_busy: got rv=%b rdy=%b want rv=0 rdy=0", rv[1], rdy[1]);
    end
    rst_n[1] = 1'b0;
    #1;
    n_checks++;
    if (rdy[1] !== 1'b1 || rv[1] !== 1'b0 || rd[1] !== 32'h0 || re[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got rdy=%b rv=%b rd=%h err=%b want 1 0 0 0", rdy[1], rv[1], rd[1], re[1]);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    txn(1, 1'b0, 32'h8, 32'h0, 4'hF, 1, 1'b0, g, ge);
    n_checks++;
    if (g !== 32'hA5A50001) begin n_errors++; $display("FAIL reset_no_write: got %h want a5a50001", g); end
  endtask

  task automatic test_random;
    logic [31:0] g; logic ge; logic [31:0] addr; int sel;
    for (int d = 0; d < 3; d++) begin
      for (int wi = 0; wi < 16; wi++) begin
        txn(d, 1'b1, 32'(wi * 4), $urandom, 4'hF, 0, 1'b0, g, ge);
      end
      for (int n = 0; n < 40; n++) begin
        sel = $urandom_range(0, 7);
        if (sel == 0) begin
          if ($urandom_range(0, 1) == 1) addr = 32'h400 + 32'($urandom_range(0, 255) * 4);
          else                           addr = 32'h80000000 | ($urandom & 32'hFFC);
        end else begin
          addr = 32'($urandom_range(0, 15) * 4);
          if (sel == 1) addr = addr + 32'($urandom_range(1, 3));
        end
        txn(d, 1'($urandom_range(0, 1)), addr, $urandom, pick_be($urandom_range(0, 8)),
            $urandom_range(0, 3), 1'b0, g, ge);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_errors();
    test_subword();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
